// File: rtl/rgb_to_cmyk_stream.sv
// Streaming RGB->CMYK converter: 3-stage valid/ready pipeline with collapsing bubbles,
// per-pixel mode (UCR CMYK / plain CMY / grey-K), end-of-line sideband and line pixel counter.

module rgb_to_cmyk_chan #(
  parameter int P = 8
) (
  input  logic [1:0]   mode,
  input  logic [P-1:0] mx,
  input  logic [P-1:0] ch,
  output logic [P-1:0] cmy
);
  localparam logic [P-1:0] FULL = '1;

  // mx >= ch by construction, so the UCR subtraction never wraps
  always_comb begin
    case (mode)
      2'b00:   cmy = mx - ch;
      2'b10:   cmy = '0;
      default: cmy = FULL - ch;
    endcase
  end
endmodule

module rgb_to_cmyk_stream #(
  parameter int COLOR_PRECISION = 8,
  parameter int CNT_W           = 12
) (
  input  logic                       i_sysclk,
  input  logic                       i_arst,
  input  logic [1:0]                 i_mode,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [COLOR_PRECISION-1:0] i_R,
  input  logic [COLOR_PRECISION-1:0] i_G,
  input  logic [COLOR_PRECISION-1:0] i_B,
  input  logic                       i_last,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [COLOR_PRECISION-1:0] o_C,
  output logic [COLOR_PRECISION-1:0] o_M,
  output logic [COLOR_PRECISION-1:0] o_Y,
  output logic [COLOR_PRECISION-1:0] o_K,
  output logic                       o_last,
  output logic [CNT_W-1:0]           o_pix_cnt
);
  localparam int P      = COLOR_PRECISION;
  localparam int STAGES = 3;
  localparam int NCH    = 3;
  localparam logic [P-1:0] FULL = '1;

  typedef struct packed {
    logic                  last;
    logic [1:0]            mode;
    logic [NCH-1:0][P-1:0] rgb;   // [0]=R [1]=G [2]=B
    logic [P-1:0]          mx;
    logic [P+1:0]          lsum;
  } s1_t;

  typedef struct packed {
    logic                  last;
    logic [1:0]            mode;
    logic [NCH-1:0][P-1:0] rgb;
    logic [P-1:0]          mx;
    logic [P-1:0]          luma;
  } s2_t;

  logic [STAGES:1]       vld_q;
  logic [STAGES:0]       vld_pipe;
  logic [STAGES:1]       ld;
  s1_t                   s1;
  s2_t                   s2;
  logic [NCH-1:0][P-1:0] cmy;
  logic [P-1:0]          k_nxt;
  logic [1:0]            mode_in;
  logic [P-1:0]          mx_rg;
  logic [P+1:0]          lsum_in;

  assign vld_pipe = {vld_q, i_valid};
  assign o_valid  = vld_q[STAGES];
  assign o_ready  = ld[1];

  // A stage loads when empty or when its successor loads; this chains i_ready
  // combinationally back to o_ready so bubbles collapse.
  always_comb begin
    ld         = '0;
    ld[STAGES] = ~vld_q[STAGES] | i_ready;
    for (int n = STAGES - 1; n >= 1; n--)
      ld[n] = ~vld_q[n] | ld[n+1];
  end

  assign mode_in = (i_mode == 2'b11) ? 2'b01 : i_mode;
  assign mx_rg   = (i_R > i_G) ? i_R : i_G;
  assign lsum_in = {2'b00, i_R} + {1'b0, i_G, 1'b0} + {2'b00, i_B};

  genvar ch;
  generate
    for (ch = 0; ch < NCH; ch++) begin : g_chan
      rgb_to_cmyk_chan #(.P(P)) u_chan (
        .mode (s2.mode),
        .mx   (s2.mx),
        .ch   (s2.rgb[ch]),
        .cmy  (cmy[ch])
      );
    end
  endgenerate

  always_comb begin
    case (s2.mode)
      2'b00:   k_nxt = FULL - s2.mx;
      2'b10:   k_nxt = FULL - s2.luma;
      default: k_nxt = '0;
    endcase
  end

  always_ff @(posedge i_sysclk) begin
    if (i_arst) begin
      vld_q     <= '0;
      s1        <= '0;
      s2        <= '0;
      o_C       <= '0;
      o_M       <= '0;
      o_Y       <= '0;
      o_K       <= '0;
      o_last    <= 1'b0;
      o_pix_cnt <= '0;
    end else begin
      for (int n = 1; n <= STAGES; n++)
        if (ld[n]) vld_q[n] <= vld_pipe[n-1];

      if (ld[1] && i_valid) begin
        s1.last <= i_last;
        s1.mode <= mode_in;
        s1.rgb  <= {i_B, i_G, i_R};
        s1.mx   <= mx_rg;
        s1.lsum <= lsum_in;
      end

      if (ld[2] && vld_q[1]) begin
        s2.last <= s1.last;
        s2.mode <= s1.mode;
        s2.rgb  <= s1.rgb;
        s2.mx   <= (s1.mx > s1.rgb[2]) ? s1.mx : s1.rgb[2];
        s2.luma <= s1.lsum[P+1:2];
      end

      if (ld[3] && vld_q[2]) begin
        o_C    <= cmy[0];
        o_M    <= cmy[1];
        o_Y    <= cmy[2];
        o_K    <= k_nxt;
        o_last <= s2.last;
      end

      // counter shows pixels already sent in this line, so it steps after each transfer
      if (o_valid && i_ready)
        o_pix_cnt <= o_last ? '0 : o_pix_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_rgb_to_cmyk_stream.sv
// Bench for rgb_to_cmyk_stream: queue-based pixel model checked every cycle plus
// directed vectors with literal expected values.

module tb_rgb_to_cmyk_stream;
  logic       i_sysclk = 1'b0;
  logic       i_arst   = 1'b1;
  logic [1:0] i_mode   = 2'b00;
  logic       i_valid  = 1'b0;
  logic       o_ready;
  logic [7:0] i_R = '0, i_G = '0, i_B = '0;
  logic       i_last   = 1'b0;
  logic       o_valid;
  logic       i_ready  = 1'b1;
  logic [7:0] o_C, o_M, o_Y, o_K;
  logic       o_last;
  logic [11:0] o_pix_cnt;

  rgb_to_cmyk_stream #(.COLOR_PRECISION(8), .CNT_W(12)) dut (
    .i_sysclk (i_sysclk), .i_arst (i_arst), .i_mode (i_mode), .i_valid (i_valid),
    .o_ready (o_ready), .i_R (i_R), .i_G (i_G), .i_B (i_B), .i_last (i_last),
    .o_valid (o_valid), .i_ready (i_ready), .o_C (o_C), .o_M (o_M), .o_Y (o_Y),
    .o_K (o_K), .o_last (o_last), .o_pix_cnt (o_pix_cnt)
  );

  always #5 i_sysclk = ~i_sysclk;

  typedef struct { int c; int m; int y; int k; bit last; } exp_t;

  exp_t q[$];
  int   tests = 0, fails = 0;
  int   mcnt = 0, out_cnt = 0;
  int   cnt_log[$], last_log[$], k_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int mode, input int r, input int g, input int b, input bit last);
    exp_t e;
    int mx;
    e.last = last;
    mx = r;
    if (g > mx) mx = g;
    if (b > mx) mx = b;
    if (mode == 0) begin
      e.k = 255 - mx; e.c = mx - r; e.m = mx - g; e.y = mx - b;
    end else if (mode == 2) begin
      e.k = 255 - (r + 2 * g + b) / 4; e.c = 0; e.m = 0; e.y = 0;
    end else begin
      e.k = 0; e.c = 255 - r; e.m = 255 - g; e.y = 255 - b;
    end
    return e;
  endfunction

  // Every cycle: ready follows occupancy, and any presented pixel must be the oldest accepted one.
  always @(negedge i_sysclk) begin
    if (i_arst) begin
      q.delete();
      mcnt = 0;
    end else begin
      chk("ready", o_ready, !(q.size() == 3 && !i_ready));
      if (o_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", o_valid, 1'b0);
        end else begin
          chk("pix", {o_C, o_M, o_Y, o_K},
              {q[0].c[7:0], q[0].m[7:0], q[0].y[7:0], q[0].k[7:0]});
          chk("last", o_last, q[0].last);
          chk("pix_cnt", o_pix_cnt, mcnt);
          if (i_ready) begin
            cnt_log.push_back(int'(o_pix_cnt));
            last_log.push_back(int'(o_last));
            k_log.push_back(int'(o_K));
            out_cnt++;
            mcnt = q[0].last ? 0 : (mcnt + 1) % 4096;
            void'(q.pop_front());
          end
        end
      end
      if (i_valid && o_ready)
        q.push_back(model(int'(i_mode), int'(i_R), int'(i_G), int'(i_B), i_last));
    end
  end

  // Entered and left at posedge+1; holds the pixel until the DUT takes it.
  task automatic send(input logic [1:0] m, input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b, input logic l);
    int  guard = 0;
    logic took;
    i_valid = 1'b1; i_mode = m; i_R = r; i_G = g; i_B = b; i_last = l;
    do begin
      #1 took = o_ready;
      @(posedge i_sysclk); #1;
      guard++;
    end while (!took && guard < 50);
    if (!took) chk("send_timeout", 1'b0, 1'b1);
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 50) begin
      @(posedge i_sysclk); #1;
      guard++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic do_reset();
    i_valid = 1'b0; i_arst = 1'b1;
    @(posedge i_sysclk); #1;
    @(posedge i_sysclk); #1;
    i_arst = 1'b0;
  endtask

  // Single pixel, free-flowing output: latency must be exactly 3 clocks.
  task automatic one_px(input string name, input logic [1:0] m, input logic [7:0] r,
                        input logic [7:0] g, input logic [7:0] b, input logic [31:0] exp_cmyk);
    send(m, r, g, b, 1'b0);
    @(posedge i_sysclk); #1;
    chk({name, "_lat2"}, o_valid, 1'b0);
    @(posedge i_sysclk); #1;
    chk({name, "_lat3"}, o_valid, 1'b1);
    chk(name, {o_C, o_M, o_Y, o_K}, exp_cmyk);
    drain();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : main
    int   idx, cyc, start;
    logic took, saw_stall;

    @(posedge i_sysclk); #1;
    do_reset();
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_cnt", o_pix_cnt, 12'd0);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_data", {o_C, o_M, o_Y, o_K, o_last}, 33'd0);

    one_px("t1_ucr",   2'b00, 8'd200, 8'd100, 8'd50,  {8'd0, 8'd100, 8'd150, 8'd55});
    one_px("t2_white", 2'b00, 8'd255, 8'd255, 8'd255, {8'd0, 8'd0, 8'd0, 8'd0});
    one_px("t2_black", 2'b00, 8'd0,   8'd0,   8'd0,   {8'd0, 8'd0, 8'd0, 8'd255});
    one_px("t2_green", 2'b00, 8'd0,   8'd255, 8'd0,   {8'd255, 8'd0, 8'd255, 8'd0});
    one_px("t3_cmy",   2'b01, 8'd200, 8'd100, 8'd50,  {8'd55, 8'd155, 8'd205, 8'd0});
    one_px("t3_cmy11", 2'b11, 8'd200, 8'd100, 8'd50,  {8'd55, 8'd155, 8'd205, 8'd0});
    one_px("t3_grey",  2'b10, 8'd200, 8'd100, 8'd50,  {8'd0, 8'd0, 8'd0, 8'd143});

    // 20-pixel stream with downstream stalled on cycles 5..9
    start = out_cnt; idx = 0; cyc = 0; saw_stall = 1'b0;
    while (idx < 20 && cyc < 200) begin
      i_ready = !(cyc >= 5 && cyc <= 9);
      i_valid = 1'b1;
      i_mode = 2'(idx % 4);
      i_R = 8'(idx * 13); i_G = 8'(255 - idx * 7); i_B = 8'(idx * 11);
      #1 took = o_ready;
      if (!took) saw_stall = 1'b1;
      @(posedge i_sysclk); #1;
      if (took) idx++;
      cyc++;
    end
    i_valid = 1'b0; i_ready = 1'b1;
    chk("t4_sent", idx, 20);
    chk("t4_stall_seen", saw_stall, 1'b1);
    drain();
    chk("t4_out_count", out_cnt - start, 20);

    // line of 4 with mode switch, then 2 pixels of the next line
    do_reset();
    cnt_log.delete(); last_log.delete(); k_log.delete();
    send(2'b00, 8'd10,  8'd20,  8'd30, 1'b0);
    send(2'b00, 8'd200, 8'd100, 8'd50, 1'b0);
    send(2'b01, 8'd200, 8'd100, 8'd50, 1'b0);
    send(2'b01, 8'd5,   8'd6,   8'd7,  1'b1);
    send(2'b00, 8'd1,   8'd2,   8'd3,  1'b0);
    send(2'b10, 8'd9,   8'd9,   8'd9,  1'b0);
    drain();
    chk("t5_n", cnt_log.size(), 6);
    if (cnt_log.size() == 6) begin
      chk("t5_cnt", {cnt_log[0][3:0], cnt_log[1][3:0], cnt_log[2][3:0],
                     cnt_log[3][3:0], cnt_log[4][3:0], cnt_log[5][3:0]}, 24'h012301);
      chk("t5_last", {last_log[0][0], last_log[1][0], last_log[2][0],
                      last_log[3][0], last_log[4][0], last_log[5][0]}, 6'b000100);
      chk("t5_k0_ucr", k_log[0], 225);
      chk("t5_k1_ucr", k_log[1], 55);
      chk("t5_k2_cmy", k_log[2], 0);
    end

    // reset with three pixels held
    i_ready = 1'b0;
    send(2'b00, 8'd1, 8'd2, 8'd3, 1'b0);
    send(2'b00, 8'd4, 8'd5, 8'd6, 1'b0);
    send(2'b00, 8'd7, 8'd8, 8'd9, 1'b0);
    chk("t6_full_valid", o_valid, 1'b1);
    chk("t6_full_ready", o_ready, 1'b0);
    i_arst = 1'b1;
    @(posedge i_sysclk); #1;
    i_arst = 1'b0;
    chk("t6_valid", o_valid, 1'b0);
    chk("t6_cnt", o_pix_cnt, 12'd0);
    chk("t6_ready", o_ready, 1'b1);
    i_ready = 1'b1;
    start = out_cnt;
    repeat (8) @(posedge i_sysclk);
    #1;
    chk("t6_no_ghost", out_cnt - start, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
